// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store unit: lane steering, sign extension, single-outstanding bus FSM.
// Optional LSU_MISALIGN_CHECK_EN: misaligned H/W accesses complete immediately with misaligned_o=1.
module load_store_unit (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        mem_valid_o,
    input  logic        mem_ready_i,
    output logic [31:0] mem_addr_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_wstrb_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        misaligned_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t      state_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic        mem_valid_q, mem_we_q, rsp_valid_q, misaligned_q, busy_q;
    logic [3:0]  mem_wstrb_q;
    logic [31:0] mem_addr_q, mem_wdata_q, rsp_rdata_q;

    logic        misalign_d;
    logic [3:0]  wstrb_d;
    logic [31:0] wdata_d, rdata_d, rshift;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    always_comb begin
        wstrb_d = 4'b1111;
        wdata_d = req_wdata_i;
        case (req_funct3_i[1:0])
            2'b00: begin
                wstrb_d = 4'b0001 << req_addr_i[1:0];
                wdata_d = {24'h0, req_wdata_i[7:0]} << {req_addr_i[1:0], 3'b000};
            end
            2'b01: begin
                wstrb_d = req_addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_d = req_addr_i[1] ? {req_wdata_i[15:0], 16'h0} : {16'h0, req_wdata_i[15:0]};
            end
            default: ;
        endcase
`ifdef LSU_MISALIGN_CHECK_EN
        misalign_d = (req_funct3_i[1:0] == 2'b01) ? req_addr_i[0]
                   : (req_funct3_i[1:0] != 2'b00) && (req_addr_i[1:0] != 2'b00);
`else
        misalign_d = 1'b0;
`endif
    end

    // Load extraction uses the offset/width latched at accept time.
    always_comb begin
        rshift  = mem_rdata_i >> {off_q, 3'b000};
        rbyte   = rshift[7:0];
        rhalf   = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        rdata_d = mem_rdata_i;
        case (funct3_q[1:0])
            2'b00:   rdata_d = funct3_q[2] ? {24'h0, rbyte} : {{24{rbyte[7]}}, rbyte};
            2'b01:   rdata_d = funct3_q[2] ? {16'h0, rhalf} : {{16{rhalf[15]}}, rhalf};
            default: rdata_d = mem_rdata_i;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            funct3_q     <= 3'b000;
            off_q        <= 2'b00;
            mem_valid_q  <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_wstrb_q  <= 4'b0000;
            mem_addr_q   <= 32'h0;
            mem_wdata_q  <= 32'h0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= 32'h0;
            misaligned_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        funct3_q <= req_funct3_i;
                        off_q    <= req_addr_i[1:0];
                        busy_q   <= 1'b1;
                        if (misalign_d) begin
                            state_q      <= RESP;
                            rsp_valid_q  <= 1'b1;
                            rsp_rdata_q  <= 32'h0;
                            misaligned_q <= 1'b1;
                        end else begin
                            state_q     <= REQ;
                            mem_valid_q <= 1'b1;
                            mem_addr_q  <= {req_addr_i[31:2], 2'b00};
                            mem_we_q    <= req_we_i;
                            mem_wstrb_q <= req_we_i ? wstrb_d : 4'b0000;
                            mem_wdata_q <= req_we_i ? wdata_d : 32'h0;
                        end
                    end
                end
                REQ: begin
                    if (mem_ready_i) begin
                        mem_valid_q <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_wstrb_q <= 4'b0000;
                        if (mem_we_q) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= 32'h0;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (mem_rvalid_i) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= rdata_d;
                    end
                end
                RESP: begin
                    state_q      <= IDLE;
                    rsp_valid_q  <= 1'b0;
                    misaligned_q <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o  = ~busy_q;
    assign busy_o       = busy_q;
    assign mem_valid_o  = mem_valid_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_we_o     = mem_we_q;
    assign mem_wstrb_o  = mem_wstrb_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_rdata_o  = rsp_rdata_q;
    assign misaligned_o = misaligned_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized self-checking bench for load_store_unit against a byte-lane model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b0;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
    logic        mem_valid, mem_ready = 1'b0, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        rsp_valid, misaligned, busy;
    logic [31:0] rsp_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    load_store_unit dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_funct3_i(req_funct3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .mem_valid_o(mem_valid), .mem_ready_i(mem_ready), .mem_addr_o(mem_addr),
        .mem_we_o(mem_we), .mem_wstrb_o(mem_wstrb), .mem_wdata_o(mem_wdata),
        .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
        .misaligned_o(misaligned), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Reference model: access width in bytes and the lane it lands on.
    function automatic int nbytes_of(input logic [2:0] f);
        case (f)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic int lane_of(input logic [2:0] f, input logic [31:0] a);
        int nb = nbytes_of(f);
        int o  = int'(a % 4);
        if (nb == 1) return o;
        if (nb == 2) return (o / 2) * 2;
        return 0;
    endfunction

    function automatic logic exp_mis(input logic [2:0] f, input logic [31:0] a);
`ifdef LSU_MISALIGN_CHECK_EN
        int nb = nbytes_of(f);
        return (nb > 1) && ((a % nb) != 0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
        int     nb = nbytes_of(f);
        longint v;
        v = (longint'(d) >> (8 * lane_of(f, a))) & ((64'd1 << (8 * nb)) - 1);
        if (nb < 4 && f < 3'd4 && v >= (64'd1 << (8 * nb - 1)))
            v = v - (64'd1 << (8 * nb));
        return v[31:0];
    endfunction

    function automatic logic [3:0] exp_strb(input logic [2:0] f, input logic [31:0] a);
        longint s = ((64'd1 << nbytes_of(f)) - 1) << lane_of(f, a);
        return s[3:0];
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f, input logic [31:0] a, input logic [31:0] w);
        longint v = (longint'(w) & ((64'd1 << (8 * nbytes_of(f))) - 1)) << (8 * lane_of(f, a));
        return v[31:0];
    endfunction

    task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rdata, input int rdy_dly, input int rv_dly,
                       output logic [31:0] o_addr, output logic [3:0] o_strb,
                       output logic [31:0] o_wdata, output logic [31:0] o_rdata);
        logic        mis  = exp_mis(f3, addr);
        logic [31:0] e_rd = we ? 32'h0 : exp_load(f3, addr, rdata);
        logic [3:0]  e_sb = exp_strb(f3, addr);
        logic [31:0] e_wd = exp_wdata(f3, addr, wdata);
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL accept_ready: got %b want 1", req_ready); end
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        step;
        req_valid = 1'b0;
        o_addr = mem_addr; o_strb = mem_wstrb; o_wdata = mem_wdata; o_rdata = 32'h0;
        if (mis) begin
            n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL mis_rsp_valid: got %b want 1", rsp_valid); end
            n_checks++; if (misaligned !== 1'b1) begin n_fail++; $display("FAIL mis_flag: got %b want 1", misaligned); end
            n_checks++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL mis_no_bus: got %b want 0", mem_valid); end
            n_checks++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL mis_rdata: got %h want 0", rsp_rdata); end
            o_rdata = rsp_rdata;
        end else begin
            for (int d = 0; d <= rdy_dly; d++) begin
                n_checks++; if (mem_valid !== 1'b1) begin n_fail++; $display("FAIL req_mem_valid: got %b want 1", mem_valid); end
                n_checks++; if (mem_addr !== {addr[31:2], 2'b00}) begin n_fail++; $display("FAIL req_mem_addr: got %h want %h", mem_addr, {addr[31:2], 2'b00}); end
                n_checks++; if (mem_we !== we) begin n_fail++; $display("FAIL req_mem_we: got %b want %b", mem_we, we); end
                if (we) begin
                    n_checks++; if (mem_wstrb !== e_sb) begin n_fail++; $display("FAIL req_wstrb: got %b want %b", mem_wstrb, e_sb); end
                    n_checks++; if (mem_wdata !== e_wd) begin n_fail++; $display("FAIL req_wdata: got %h want %h", mem_wdata, e_wd); end
                end
                n_checks++; if (busy !== 1'b1 || req_ready !== 1'b0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL req_stall: busy=%b ready=%b rsp=%b want 1 0 0", busy, req_ready, rsp_valid); end
                mem_ready  = (d == rdy_dly);
                mem_rvalid = 1'($urandom_range(0, 1));
                mem_rdata  = $urandom;
                step;
            end
            mem_ready = 1'b0; mem_rvalid = 1'b0;
            if (!we) begin
                for (int d = 0; d <= rv_dly; d++) begin
                    n_checks++; if (mem_valid !== 1'b0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wait_idle_bus: mem_valid=%b rsp=%b want 0 0", mem_valid, rsp_valid); end
                    mem_rvalid = (d == rv_dly);
                    mem_rdata  = (d == rv_dly) ? rdata : $urandom;
                    step;
                end
                mem_rvalid = 1'b0;
            end
            n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rsp_valid: got %b want 1", rsp_valid); end
            n_checks++; if (rsp_rdata !== e_rd) begin n_fail++; $display("FAIL rsp_rdata: got %h want %h", rsp_rdata, e_rd); end
            n_checks++; if (misaligned !== 1'b0) begin n_fail++; $display("FAIL rsp_misaligned: got %b want 0", misaligned); end
            n_checks++; if (req_ready !== 1'b0 || mem_valid !== 1'b0) begin n_fail++; $display("FAIL rsp_ready: ready=%b mem_valid=%b want 0 0", req_ready, mem_valid); end
            o_rdata = rsp_rdata;
        end
        // Offer a request during the response cycle; it must not be taken.
        req_valid = 1'b1; req_we = 1'($urandom_range(0, 1)); req_addr = $urandom; req_funct3 = 3'b010;
        step;
        n_checks++; if (rsp_valid !== 1'b0 || mem_valid !== 1'b0 || misaligned !== 1'b0) begin n_fail++; $display("FAIL post_rsp_quiet: rsp=%b mem_valid=%b mis=%b want 0 0 0", rsp_valid, mem_valid, misaligned); end
        n_checks++; if (req_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL post_rsp_idle: ready=%b busy=%b want 1 0", req_ready, busy); end
        req_valid = 1'b0;
    endtask

    task automatic test_reset;
        step; step;
        n_checks++; if (mem_valid !== 1'b0 || mem_we !== 1'b0 || rsp_valid !== 1'b0 || misaligned !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_flags: mv=%b we=%b rv=%b mis=%b busy=%b want all 0", mem_valid, mem_we, rsp_valid, misaligned, busy); end
        n_checks++; if (mem_wstrb !== 4'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 || rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_data: strb=%h addr=%h wd=%h rd=%h want 0", mem_wstrb, mem_addr, mem_wdata, rsp_rdata); end
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        rst_n = 1'b1;
        step;
    endtask

    task automatic test_spec_vectors;
        logic [31:0] a, w, r;
        logic [3:0]  s;
        txn(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, a, s, w, r);
        n_checks++; if (a !== 32'h100 || r !== 32'hDEADBEEF) begin n_fail++; $display("FAIL load_w: addr=%h rdata=%h want 100 deadbeef", a, r); end
        txn(1'b0, 3'b000, 32'h103, 32'h0, 32'h80112233, 0, 0, a, s, w, r);
        n_checks++; if (r !== 32'hFFFFFF80) begin n_fail++; $display("FAIL load_b_sext: got %h want ffffff80", r); end
        txn(1'b0, 3'b100, 32'h103, 32'h0, 32'h80112233, 1, 2, a, s, w, r);
        n_checks++; if (r !== 32'h00000080) begin n_fail++; $display("FAIL load_bu: got %h want 00000080", r); end
        txn(1'b1, 3'b001, 32'h202, 32'h0000ABCD, 32'h0, 0, 0, a, s, w, r);
        n_checks++; if (a !== 32'h200 || s !== 4'b1100 || w[31:16] !== 16'hABCD) begin n_fail++; $display("FAIL store_h: addr=%h strb=%b wd=%h want 200 1100 abcd....", a, s, w); end
        txn(1'b1, 3'b010, 32'h300, 32'h12345678, 32'h0, 5, 0, a, s, w, r);
        n_checks++; if (s !== 4'b1111 || w !== 32'h12345678) begin n_fail++; $display("FAIL store_w_stall: strb=%b wd=%h want 1111 12345678", s, w); end
`ifdef LSU_MISALIGN_CHECK_EN
        txn(1'b0, 3'b010, 32'h101, 32'h0, 32'h55AA55AA, 0, 0, a, s, w, r);
        n_checks++; if (r !== 32'h0) begin n_fail++; $display("FAIL misaligned_w: got %h want 0", r); end
`else
        txn(1'b0, 3'b001, 32'h203, 32'h0, 32'hBEEF1234, 0, 0, a, s, w, r);
        n_checks++; if (r !== 32'hFFFFBEEF) begin n_fail++; $display("FAIL unaligned_h_lane: got %h want ffffbeef", r); end
`endif
    endtask

    task automatic test_random;
        logic [31:0] a, w, r;
        logic [3:0]  s;
        for (int i = 0; i < 60; i++)
            txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                $urandom_range(0, 3), $urandom_range(0, 3), a, s, w, r);
    endtask

    task automatic test_reset_mid;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h40;
        step;
        req_valid = 1'b0; mem_ready = 1'b1;
        step;
        mem_ready = 1'b0;
        n_checks++; if (busy !== 1'b1 || mem_valid !== 1'b0) begin n_fail++; $display("FAIL mid_in_wait: busy=%b mem_valid=%b want 1 0", busy, mem_valid); end
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_async_reset: busy=%b ready=%b rsp=%b want 0 1 0", busy, req_ready, rsp_valid); end
        #1 rst_n = 1'b1;
        step;
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
        step;
        mem_rvalid = 1'b0;
        n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_stray_rvalid: rsp=%b ready=%b busy=%b want 0 1 0", rsp_valid, req_ready, busy); end
        step;
        n_checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL mid_no_rsp: rsp=%b rdata=%h want 0 0", rsp_valid, rsp_rdata); end
    endtask

    initial begin
        test_reset;
        test_spec_vectors;
        test_random;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
